// File: rtl/fpga_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : fpga_rst_seq
// Description : Board reset sequencer combining PLL lock, debounced button and
//               optional UART break (UART_BREAK_RST_EN) into a clean SoC reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_rst_seq #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int HOLD_CYCLES     = 1024,
    parameter int BREAK_CYCLES    = 200000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       btn_rst_n_i,
    input  logic       uart_rx_i,
    output logic       soc_rst_n_o,
    output logic [1:0] rst_cause_o,
    output logic [7:0] rst_cnt_o,
    output logic [1:0] state_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HD_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   lock_s;
    logic                   btn_s;
    logic                   btn_db;
    logic [DB_W-1:0]        db_cnt;
    logic [HD_W-1:0]        hold_cnt;
    logic                   press;
    logic                   brk;
    logic                   src_active;
    logic [1:0]             cause_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync <= '0;
            btn_sync  <= '1;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_rst_n_i};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign btn_s  = btn_sync[SYNC_STAGES-1];

    // A new button level is accepted only after it holds for DEBOUNCE_CYCLES
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_db <= 1'b1;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    assign press = ~btn_db;

`ifdef UART_BREAK_RST_EN
    localparam int BR_W = $clog2(BREAK_CYCLES + 1);

    logic [SYNC_STAGES-1:0] rx_sync;
    logic [BR_W-1:0]        brk_cnt;
    logic                   rx_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_sync <= '1;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], uart_rx_i};
        end
    end

    assign rx_s = rx_sync[SYNC_STAGES-1];

    // Saturating counter keeps break asserted until the line returns high
    always_ff @(posedge clk_i) begin
        if (rst_i || rx_s) begin
            brk_cnt <= '0;
        end else if (brk_cnt != BR_W'(BREAK_CYCLES)) begin
            brk_cnt <= brk_cnt + BR_W'(1);
        end
    end

    assign brk = (brk_cnt == BR_W'(BREAK_CYCLES));
`else
    logic unused_rx;
    assign unused_rx = uart_rx_i;
    assign brk       = 1'b0;
`endif

    assign src_active = ~lock_s | press | brk;

    always_comb begin
        next_state = state;
        case (state)
            ST_WAIT: begin
                if (!src_active) begin
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (src_active) begin
                    next_state = ST_WAIT;
                end else if (hold_cnt == HD_W'(HOLD_CYCLES - 1)) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (src_active) begin
                    next_state = ST_WAIT;
                end
            end
            default: next_state = ST_WAIT;
        endcase
    end

    always_comb begin
        cause_next = 2'd3;
        if (!lock_s) begin
            cause_next = 2'd2;
        end else if (press) begin
            cause_next = 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_WAIT;
            hold_cnt    <= '0;
            soc_rst_n_o <= 1'b0;
            rst_cause_o <= 2'd0;
            rst_cnt_o   <= 8'd0;
        end else begin
            state       <= next_state;
            hold_cnt    <= (state == ST_HOLD) ? hold_cnt + HD_W'(1) : '0;
            soc_rst_n_o <= (next_state == ST_RUN);
            if (state == ST_RUN && next_state == ST_WAIT) begin
                rst_cause_o <= cause_next;
                if (rst_cnt_o != 8'hFF) begin
                    rst_cnt_o <= rst_cnt_o + 8'd1;
                end
            end
        end
    end

    assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_fpga_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpga_rst_seq
// Description : Directed self-checking bench for fpga_rst_seq (small timing).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_rst_seq;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       pll_locked_i = 1'b1;
    logic       btn_rst_n_i = 1'b1;
    logic       uart_rx_i = 1'b1;
    logic       soc_rst_n_o;
    logic [1:0] rst_cause_o;
    logic [7:0] rst_cnt_o;
    logic [1:0] state_o;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    fpga_rst_seq #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .HOLD_CYCLES    (16),
        .BREAK_CYCLES   (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pll_locked_i(pll_locked_i),
        .btn_rst_n_i (btn_rst_n_i),
        .uart_rx_i   (uart_rx_i),
        .soc_rst_n_o (soc_rst_n_o),
        .rst_cause_o (rst_cause_o),
        .rst_cnt_o   (rst_cnt_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_run(input string name);
        int k;
        k = 0;
        while (state_o !== 2'd2 && k < 200) begin
            tick(1);
            k++;
        end
        checks++;
        if (state_o !== 2'd2 || soc_rst_n_o !== 1'b1) begin
            errors++;
            $display("FAIL %s: state=%0d soc=%b, required RUN with soc=1 within 200 cycles",
                     name, state_o, soc_rst_n_o);
        end
    endtask

    task automatic pulse_lock();
        pll_locked_i = 1'b0;
        tick(1);
        pll_locked_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(3);
        checks++;
        if ({soc_rst_n_o, rst_cause_o, rst_cnt_o, state_o} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: soc=%b cause=%0d cnt=%0d state=%0d, required all 0",
                     soc_rst_n_o, rst_cause_o, rst_cnt_o, state_o);
        end
    endtask

    task automatic test_startup();
        rst_i = 1'b0;
        tick(2);
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL start_wait_e2: state=%0d, required 0", state_o);
        end
        tick(1);
        checks++;
        if (state_o !== 2'd1) begin
            errors++;
            $display("FAIL start_hold_e3: state=%0d, required 1", state_o);
        end
        tick(15);
        checks++;
        if (soc_rst_n_o !== 1'b0 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL start_e18: soc=%b state=%0d, required soc=0 state=1", soc_rst_n_o, state_o);
        end
        tick(1);
        checks++;
        if (soc_rst_n_o !== 1'b1 || state_o !== 2'd2 || rst_cause_o !== 2'd0 || rst_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL start_run_e19: soc=%b state=%0d cause=%0d cnt=%0d, required 1/2/0/0",
                     soc_rst_n_o, state_o, rst_cause_o, rst_cnt_o);
        end
    endtask

    task automatic test_button_bounce();
        btn_rst_n_i = 1'b0;
        tick(5);
        btn_rst_n_i = 1'b1;
        tick(20);
        checks++;
        if (soc_rst_n_o !== 1'b1 || rst_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL button_bounce: soc=%b cnt=%0d, required soc=1 cnt=0", soc_rst_n_o, rst_cnt_o);
        end
    endtask

    task automatic test_button_press();
        btn_rst_n_i = 1'b0;
        tick(10);
        checks++;
        if (soc_rst_n_o !== 1'b1) begin
            errors++;
            $display("FAIL press_e10: soc=%b, required 1", soc_rst_n_o);
        end
        tick(1);
        exp_cnt++;
        checks++;
        if (soc_rst_n_o !== 1'b0 || state_o !== 2'd0 || rst_cause_o !== 2'd1 || rst_cnt_o !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL press_e11: soc=%b state=%0d cause=%0d cnt=%0d, required 0/0/1/%0d",
                     soc_rst_n_o, state_o, rst_cause_o, rst_cnt_o, exp_cnt);
        end
        tick(9);
        btn_rst_n_i = 1'b1;
        tick(26);
        checks++;
        if (soc_rst_n_o !== 1'b0 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL release_e26: soc=%b state=%0d, required soc=0 state=1", soc_rst_n_o, state_o);
        end
        tick(1);
        checks++;
        if (soc_rst_n_o !== 1'b1 || state_o !== 2'd2) begin
            errors++;
            $display("FAIL release_e27: soc=%b state=%0d, required soc=1 state=2", soc_rst_n_o, state_o);
        end
    endtask

    task automatic test_pll_loss();
        pulse_lock();
        tick(1);
        checks++;
        if (soc_rst_n_o !== 1'b1) begin
            errors++;
            $display("FAIL pll_e2: soc=%b, required 1", soc_rst_n_o);
        end
        tick(1);
        exp_cnt++;
        checks++;
        if (soc_rst_n_o !== 1'b0 || rst_cause_o !== 2'd2 || rst_cnt_o !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL pll_e3: soc=%b cause=%0d cnt=%0d, required 0/2/%0d",
                     soc_rst_n_o, rst_cause_o, rst_cnt_o, exp_cnt);
        end
        wait_run("pll_recover");
        pll_locked_i = 1'b0;
        btn_rst_n_i  = 1'b0;
        tick(1);
        pll_locked_i = 1'b1;
        btn_rst_n_i  = 1'b1;
        tick(2);
        exp_cnt++;
        checks++;
        if (soc_rst_n_o !== 1'b0 || rst_cause_o !== 2'd2 || rst_cnt_o !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL simul_cause: soc=%b cause=%0d cnt=%0d, required 0/2/%0d",
                     soc_rst_n_o, rst_cause_o, rst_cnt_o, exp_cnt);
        end
        wait_run("simul_recover");
    endtask

    task automatic test_hold_abort();
        pulse_lock();
        exp_cnt++;
        tick(13);
        pll_locked_i = 1'b0;
        tick(2);
        checks++;
        if (state_o !== 2'd1) begin
            errors++;
            $display("FAIL abort_in_hold: state=%0d, required 1", state_o);
        end
        tick(1);
        checks++;
        if (state_o !== 2'd0 || soc_rst_n_o !== 1'b0 || rst_cause_o !== 2'd2 || rst_cnt_o !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL abort_wait: state=%0d soc=%b cause=%0d cnt=%0d, required 0/0/2/%0d",
                     state_o, soc_rst_n_o, rst_cause_o, rst_cnt_o, exp_cnt);
        end
        pll_locked_i = 1'b1;
        wait_run("abort_recover");
        checks++;
        if (rst_cnt_o !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL abort_cnt: cnt=%0d, required %0d", rst_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_break();
        uart_rx_i = 1'b0;
`ifdef UART_BREAK_RST_EN
        tick(34);
        checks++;
        if (state_o !== 2'd2) begin
            errors++;
            $display("FAIL break_e34: state=%0d, required 2", state_o);
        end
        tick(1);
        exp_cnt++;
        checks++;
        if (state_o !== 2'd0 || rst_cause_o !== 2'd3 || rst_cnt_o !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL break_e35: state=%0d cause=%0d cnt=%0d, required 0/3/%0d",
                     state_o, rst_cause_o, rst_cnt_o, exp_cnt);
        end
        tick(5);
        uart_rx_i = 1'b1;
        tick(3);
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL break_held_e43: state=%0d, required 0", state_o);
        end
        tick(1);
        checks++;
        if (state_o !== 2'd1) begin
            errors++;
            $display("FAIL break_hold_e44: state=%0d, required 1", state_o);
        end
        wait_run("break_recover");
`else
        tick(40);
        uart_rx_i = 1'b1;
        tick(10);
`endif
        checks++;
        if (rst_cnt_o !== 8'(exp_cnt) || soc_rst_n_o !== 1'b1) begin
            errors++;
            $display("FAIL break_count: cnt=%0d soc=%b, required cnt=%0d soc=1",
                     rst_cnt_o, soc_rst_n_o, exp_cnt);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            pulse_lock();
            tick(2);
            if (exp_cnt < 255) exp_cnt++;
            if (i == 100 || i == 249 || i == 299) begin
                checks++;
                if (rst_cnt_o !== 8'(exp_cnt)) begin
                    errors++;
                    $display("FAIL saturate_%0d: cnt=%0d, required %0d", i, rst_cnt_o, exp_cnt);
                end
            end
            wait_run("saturate_recover");
        end
    endtask

    task automatic test_rst_mid();
        rst_i = 1'b1;
        tick(1);
        checks++;
        if ({soc_rst_n_o, rst_cause_o, rst_cnt_o, state_o} !== 13'd0) begin
            errors++;
            $display("FAIL rst_mid: soc=%b cause=%0d cnt=%0d state=%0d, required all 0",
                     soc_rst_n_o, rst_cause_o, rst_cnt_o, state_o);
        end
        rst_i = 1'b0;
        exp_cnt = 0;
        wait_run("rst_mid_recover");
    endtask

    initial begin
        test_reset();
        test_startup();
        test_button_bounce();
        test_button_press();
        test_pll_loss();
        test_hold_abort();
        test_break();
        test_saturate();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
